// File: rtl/multicycle_cpu.sv
// Five-state multicycle CPU: FETCH/DECODE/EXEC/MEM/WB over a 4-entry register file
// and a small data memory. The 8-bit ISA covers ADD, ADDI, LW, SW and BEQ.
module multicycle_cpu #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 32
) (
    input  logic              clk_1s,
    input  logic              reset,
    input  logic              run,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc,
    output logic              wb_valid,
    output logic [1:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        state
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_LS   = 2'b10;
    localparam logic [1:0] OP_BEQ  = 2'b11;

    function automatic logic [DATA_W-1:0] sext_data(input logic [1:0] imm);
        return {{(DATA_W-2){imm[1]}}, imm};
    endfunction

    function automatic logic [PC_W-1:0] sext_pc(input logic [1:0] imm);
        return {{(PC_W-2){imm[1]}}, imm};
    endfunction

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                wb_valid_q, wb_valid_d;
    logic [1:0]          wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   mem_q  [DMEM_DEPTH];

    logic [1:0]          op, rs, rt, rd;
    logic [PC_W-1:0]     pc_inc;
    logic [AW-1:0]       mem_addr;
    logic                reg_we, mem_we;
    logic [1:0]          reg_waddr;
    logic [DATA_W-1:0]   reg_wdata;

    assign op       = ir_q[7:6];
    assign rs       = ir_q[5:4];
    assign rt       = ir_q[3:2];
    assign rd       = ir_q[1:0];
    assign pc_inc   = pc_q + PC_W'(1);
    assign mem_addr = a_q[AW-1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        reg_we    = 1'b0;
        reg_waddr = rt;
        reg_wdata = alu_q;
        mem_we    = 1'b0;
        instr_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req = run;
                if (run && instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        alu_d   = a_q + b_q;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + sext_data(ir_q[1:0]);
                        state_d = S_WB;
                    end
                    OP_LS: state_d = S_MEM;
                    default: begin
                        // BEQ resolves here and retires without a write-back
                        pc_d    = (a_q == b_q) ? (pc_inc + sext_pc(ir_q[1:0])) : pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (!ir_q[1]) begin
                    mdr_d   = mem_q[mem_addr];
                    state_d = S_WB;
                end else begin
                    mem_we  = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                reg_waddr = (op == OP_ADD) ? rd : rt;
                reg_wdata = (op == OP_LS) ? mdr_q : alu_q;
                pc_d      = pc_inc;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write-back report is registered so the pulse lands the cycle after the WB edge
    always_comb begin
        wb_valid_d = reg_we;
        wb_addr_d  = reg_we ? reg_waddr : wb_addr_q;
        wb_data_d  = reg_we ? reg_wdata : wb_data_q;
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            for (int j = 0; j < DMEM_DEPTH; j++) mem_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_q      <= alu_d;
            mdr_q      <= mdr_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            if (reg_we) regs_q[reg_waddr] <= reg_wdata;
            if (mem_we) mem_q[mem_addr] <= b_q;
        end
    end

    assign pc       = pc_q;
    assign state    = state_q;
    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: arithmetic, memory, branches, pc wrap,
// stalls and asynchronous reset, with hand-computed expectations.
module tb_multicycle_cpu;

    logic       clk_1s;
    logic       reset;
    logic       run;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_req;
    logic [7:0] pc;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_cpu #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(32)) dut (
        .clk_1s      (clk_1s),
        .reset       (reset),
        .run         (run),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_req   (instr_req),
        .pc          (pc),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .state       (state)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    // Issue one instruction from FETCH and step until the core is back in FETCH,
    // plus one extra edge so a stretched wb pulse would be counted twice.
    task automatic issue(input logic [7:0] ins, input logic drop_run,
                         output int edges, output int wb_cnt,
                         output logic [1:0] wa, output logic [7:0] wd);
        edges = 0; wb_cnt = 0; wa = 2'bxx; wd = 8'hxx;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk_1s); #1;
        instr_valid = 1'b0;
        if (drop_run) run = 1'b0;
        edges = 1;
        if (wb_valid) begin wb_cnt++; wa = wb_addr; wd = wb_data; end
        while (state !== 3'd0 && edges < 20) begin
            @(posedge clk_1s); #1;
            edges++;
            if (wb_valid) begin wb_cnt++; wa = wb_addr; wd = wb_data; end
        end
        @(posedge clk_1s); #1;
        if (wb_valid) wb_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr = 8'h00;
        repeat (2) @(posedge clk_1s);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %02h want 00", pc); end
        checks++; if ({wb_valid, wb_addr, wb_data} !== 11'd0) begin errors++;
            $display("FAIL reset_wb got v=%0b a=%0d d=%02h want 0/0/00", wb_valid, wb_addr, wb_data); end
        checks++; if (instr_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", instr_req); end
        reset = 1'b0;
        @(posedge clk_1s); #1;
        run = 1'b1;
    endtask

    task automatic test_addi();
        int e, n; logic [1:0] a; logic [7:0] d;
        issue(8'h45, 1'b0, e, n, a, d);
        checks++; if (e !== 4 || n !== 1 || a !== 2'd1 || d !== 8'h01) begin errors++;
            $display("FAIL addi_r1 got edges=%0d pulses=%0d wb=(%0d,%02h) want 4/1/(1,01)", e, n, a, d); end
        issue(8'h4B, 1'b0, e, n, a, d);
        checks++; if (e !== 4 || n !== 1 || a !== 2'd2 || d !== 8'hFF) begin errors++;
            $display("FAIL addi_r2 got edges=%0d pulses=%0d wb=(%0d,%02h) want 4/1/(2,ff)", e, n, a, d); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL addi_pc got %02h want 02", pc); end
    endtask

    task automatic test_add();
        int e, n; logic [1:0] a; logic [7:0] d;
        issue(8'h1B, 1'b0, e, n, a, d);
        checks++; if (e !== 4 || n !== 1 || a !== 2'd3 || d !== 8'h00) begin errors++;
            $display("FAIL add_wrap got edges=%0d pulses=%0d wb=(%0d,%02h) want 4/1/(3,00)", e, n, a, d); end
        checks++; if (pc !== 8'h03) begin errors++; $display("FAIL add_pc got %02h want 03", pc); end
    endtask

    task automatic test_mem();
        int e, n; logic [1:0] a; logic [7:0] d;
        issue(8'h9A, 1'b0, e, n, a, d);
        checks++; if (e !== 4 || n !== 0) begin errors++;
            $display("FAIL sw got edges=%0d pulses=%0d want 4/0", e, n); end
        issue(8'h9C, 1'b0, e, n, a, d);
        checks++; if (e !== 5 || n !== 1 || a !== 2'd3 || d !== 8'hFF) begin errors++;
            $display("FAIL lw got edges=%0d pulses=%0d wb=(%0d,%02h) want 5/1/(3,ff)", e, n, a, d); end
        checks++; if (pc !== 8'h05) begin errors++; $display("FAIL mem_pc got %02h want 05", pc); end
    endtask

    task automatic test_branch();
        int e, n; logic [1:0] a; logic [7:0] d;
        issue(8'hC2, 1'b0, e, n, a, d);
        checks++; if (e !== 3 || n !== 0 || pc !== 8'h04) begin errors++;
            $display("FAIL beq_taken got edges=%0d pulses=%0d pc=%02h want 3/0/04", e, n, pc); end
        issue(8'hC6, 1'b0, e, n, a, d);
        checks++; if (e !== 3 || n !== 0 || pc !== 8'h05) begin errors++;
            $display("FAIL beq_not_taken got edges=%0d pulses=%0d pc=%02h want 3/0/05", e, n, pc); end
    endtask

    task automatic test_pc_wrap();
        int e, n; logic [1:0] a; logic [7:0] d;
        // BEQ r0,r0,+1 advances pc by 2: 5 -> 0xFF after 125 branches
        for (int i = 0; i < 125; i++) issue(8'hC1, 1'b0, e, n, a, d);
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL pc_climb got %02h want ff", pc); end
        issue(8'hC6, 1'b0, e, n, a, d);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_inc_wrap got %02h want 00", pc); end
        issue(8'hC2, 1'b0, e, n, a, d);
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL pc_branch_wrap got %02h want ff", pc); end
        issue(8'h41, 1'b0, e, n, a, d);
        checks++; if (pc !== 8'h00 || n !== 1 || a !== 2'd0 || d !== 8'h01) begin errors++;
            $display("FAIL addi_r0_wrap got pc=%02h pulses=%0d wb=(%0d,%02h) want 00/1/(0,01)", pc, n, a, d); end
    endtask

    task automatic test_stall();
        int e, n; logic [1:0] a; logic [7:0] d;
        run = 1'b0; instr = 8'h45; instr_valid = 1'b1;
        repeat (3) @(posedge clk_1s);
        #1;
        checks++; if (state !== 3'd0 || pc !== 8'h00 || instr_req !== 1'b0 || wb_valid !== 1'b0) begin errors++;
            $display("FAIL stall_run0 got st=%0d pc=%02h req=%0b wbv=%0b want 0/00/0/0", state, pc, instr_req, wb_valid); end
        run = 1'b1; instr_valid = 1'b0;
        repeat (3) @(posedge clk_1s);
        #1;
        checks++; if (state !== 3'd0 || pc !== 8'h00 || instr_req !== 1'b1) begin errors++;
            $display("FAIL stall_novalid got st=%0d pc=%02h req=%0b want 0/00/1", state, pc, instr_req); end
        // r0 is 1 here, so r1 = r0 + 1 = 2; run drops right after acceptance
        issue(8'h45, 1'b1, e, n, a, d);
        checks++; if (e !== 4 || n !== 1 || a !== 2'd1 || d !== 8'h02 || pc !== 8'h01) begin errors++;
            $display("FAIL run_drop got edges=%0d pulses=%0d wb=(%0d,%02h) pc=%02h want 4/1/(1,02)/01", e, n, a, d, pc); end
        instr = 8'h45; instr_valid = 1'b1;
        repeat (3) @(posedge clk_1s);
        #1;
        checks++; if (state !== 3'd0 || pc !== 8'h01 || instr_req !== 1'b0) begin errors++;
            $display("FAIL run_drop_hold got st=%0d pc=%02h req=%0b want 0/01/0", state, pc, instr_req); end
        instr_valid = 1'b0; run = 1'b1;
    endtask

    task automatic test_reset_mid();
        int e, n; logic [1:0] a; logic [7:0] d;
        instr = 8'h1B; instr_valid = 1'b1;
        @(posedge clk_1s); #1;
        instr_valid = 1'b0;
        @(posedge clk_1s); #1;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL reach_exec got %0d want 2", state); end
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || pc !== 8'h00 || wb_valid !== 1'b0) begin errors++;
            $display("FAIL async_reset got st=%0d pc=%02h wbv=%0b want 0/00/0", state, pc, wb_valid); end
        @(posedge clk_1s); #1;
        reset = 1'b0;
        @(posedge clk_1s); #1;
        checks++; if (wb_valid !== 1'b0 || state !== 3'd0 || pc !== 8'h00) begin errors++;
            $display("FAIL post_reset got wbv=%0b st=%0d pc=%02h want 0/0/00", wb_valid, state, pc); end
        // r3 = r3 + 0 exposes that the aborted ADD left r3 cleared
        issue(8'h7C, 1'b0, e, n, a, d);
        checks++; if (n !== 1 || a !== 2'd3 || d !== 8'h00 || pc !== 8'h01) begin errors++;
            $display("FAIL r3_cleared got pulses=%0d wb=(%0d,%02h) pc=%02h want 1/(3,00)/01", n, a, d, pc); end
        issue(8'h45, 1'b0, e, n, a, d);
        issue(8'h9C, 1'b0, e, n, a, d);
        checks++; if (n !== 1 || a !== 2'd3 || d !== 8'h00) begin errors++;
            $display("FAIL mem_cleared got pulses=%0d wb=(%0d,%02h) want 1/(3,00)", n, a, d); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add();
        test_mem();
        test_branch();
        test_pc_wrap();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/ALU/data-memory word width (>=4).
REQ-002 SHALL have parameter PC_W, default 8, program-counter width.
REQ-003 SHALL have parameter DMEM_DEPTH, default 32, data-memory word count (power of two).
REQ-004 SHALL have port clk_1s  in  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  in  1  1 = fetch permitted, 0 = hold in FETCH.
REQ-007 SHALL have port instr_valid  in  1  instr is valid this cycle.
REQ-008 SHALL have port instr  in  8  instruction {op[7:6], rs[5:4], rt[3:2], imm/rd[1:0]}.
REQ-009 SHALL have port instr_req  out  1  core requests the instruction at pc.
REQ-010 SHALL have port pc  out  PC_W  address of the current instruction.
REQ-011 SHALL have port wb_valid  out  1  one-cycle pulse on a register write.
REQ-012 SHALL have port wb_addr  out  2  register index written.
REQ-013 SHALL have port wb_data  out  DATA_W  value written.
REQ-014 SHALL have port state  out  3  FSM state encoding, for display.

Function
REQ-015 SHALL hold 4 x DATA_W registers r0..r3, all writable (r0 not hardwired), plus a DMEM_DEPTH x DATA_W data memory.
REQ-016 SHALL implement opcodes:
- 00 ADD: rd <= rs + rt.
- 01 ADDI: rt <= rs + sext(imm2).
- 10 with instr[1]=0 LW: rt <= M[rs].
- 10 with instr[1]=1 SW: M[rs] <= rt.
- 11 BEQ: branch if rs == rt.
- instr[0] of op 10 is ignored.
REQ-017 SHALL sign-extend imm2 to DATA_W for ADDI and to PC_W for BEQ; all sums wrap modulo 2^width, with no carry or overflow flag.
REQ-018 SHALL form the memory address as rs value modulo DMEM_DEPTH (low log2 bits).
REQ-019 SHALL use FSM states and encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-020 In FETCH, SHALL drive instr_req = run, and SHALL latch instr into IR only on an edge where run & instr_valid = 1, then go to DECODE; otherwise SHALL stay in FETCH.
REQ-021 DECODE SHALL latch A = reg[rs] and B = reg[rt], then go to EXEC.
REQ-022 EXEC transitions:
- ADD/ADDI: compute ALUOut, go to WB.
- LW/SW: go to MEM.
- BEQ: set pc <= pc+1+sext(imm2) if A==B, else pc <= pc+1; go to FETCH.
REQ-023 MEM transitions:
- LW: MDR <= M[A mod DMEM_DEPTH], go to WB.
- SW: M[addr] <= B, pc <= pc+1, go to FETCH.
REQ-024 WB SHALL write ALUOut (ADD/ADDI) or MDR (LW) to rd (ADD) or rt (ADDI/LW), set pc <= pc+1, and go to FETCH.
REQ-025 SHALL assert wb_valid for exactly the cycle after the WB edge, with wb_addr/wb_data holding the written index/value until the next register write.
REQ-026 Latency, in edges from the accepting FETCH edge to return to FETCH: BEQ 3, ADD/ADDI/SW 4, LW 5.
REQ-027 pc SHALL change only at instruction completion and SHALL wrap modulo 2^PC_W (0xFF+1 -> 0x00 at PC_W=8).
REQ-028 If run falls mid-instruction, the instruction SHALL complete, and the core SHALL then stall in FETCH.
REQ-029 instr and instr_valid SHALL be ignored outside FETCH.

Reset
REQ-030 reset high SHALL immediately force, regardless of clock:
- state=FETCH, pc=0, IR=0, A=B=ALUOut=MDR=0.
- all registers and data-memory words = 0.
- wb_valid=0, wb_addr=0, wb_data=0.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction with no register or memory write; after release, the first fetch SHALL be at pc=0.

Verification
REQ-032 After reset, run=1, feed 0x45 (ADDI r1=r0+1) then 0x4B (ADDI r2=r0-1) -> wb pulses (1,0x01) then (2,0xFF); pc=2; 4 edges each.
REQ-033 Then 0x1B (ADD r3=r1+r2) -> wb (3,0x00) from wraparound; pc=3.
REQ-034 Then 0x9A (SW M[r1]<=r2), then 0x9C (LW r3<=M[1]):
- SW: no wb pulse, 4 edges.
- LW: wb (3,0xFF), 5 edges; pc=5.
REQ-035 Branches:
- At pc=5, 0xC2 (BEQ r0,r0,-2) -> pc=4 after 3 edges, no wb.
- 0xC6 (BEQ r0,r1,-2), with r1=1 -> pc=pc+1.
- Branch/increment from pc=0xFF -> 0x00.
REQ-036 Stall and reset:
- run=0 or instr_valid=0 in FETCH -> pc, state and registers hold; instr_req=run.
- Reset pulse while state=EXEC of an ADD -> state=0, pc=0, wb_valid stays 0, and target register stays 0.
